// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: byte/word types, the forward S-box used by the
// key path and the cipher stages, the Rcon seed and GF(2^8) doubling, and the
// key-schedule controller state encoding.
package aes128_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam byte_t RCON_INIT = 8'h01;

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_round.sv
// One AES-128 key-expansion step: derives the next round key from the
// current one and the round constant. Purely combinational.
module aes128_key_round
    import aes128_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    word_t w0, w1, w2, w3;
    word_t rot;
    word_t t;
    word_t n0, n1, n2, n3;

    // Byte 0 of each word sits in the low bits, so RotWord is a right shift
    // by one byte and the Rcon byte is XORed into bits [7:0].
    always_comb begin
        w0  = key[31:0];
        w1  = key[63:32];
        w2  = key[95:64];
        w3  = key[127:96];
        rot = {w3[7:0], w3[31:8]};
        t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
              ^ {24'h000000, rcon};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        next_key = {n3, n2, n1, n0};
    end

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: pops one cipher key from the
// key-load FIFO and pushes the original key plus NUM_ROUNDS round keys to the
// round-key FIFO, one per cycle unless the output FIFO is full.
module aes128_key_sched_ctrl
    import aes128_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] in_key,
    output logic         in_key_rd,
    input  logic         in_key_empty,
    output logic [127:0] out_key,
    output logic         out_key_wr,
    input  logic         out_key_full,
    output logic [3:0]   out_round,
    output logic         busy,
    output logic         state_dbg
);

    // FIFO handshake: a pop happens on every rising edge where in_key_rd=1
    // (only raised in IDLE while in_key_empty=0, in_key is taken that edge);
    // a push happens on every rising edge where out_key_wr=1 (only raised in
    // EMIT while out_key_full=0, out_key/out_round are the pushed data).
    // The two strobes are never high together and both are low in reset.

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t       state, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   round, round_next;
    byte_t        rcon, rcon_next;
    logic [127:0] expanded_key;

    aes128_key_round u_key_round (
        .key      (key_reg),
        .rcon     (rcon),
        .next_key (expanded_key)
    );

    // State, key and counter registers; reset aborts any schedule in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            key_reg <= '0;
            round   <= 4'd0;
            rcon    <= RCON_INIT;
        end else begin
            state   <= state_next;
            key_reg <= key_next;
            round   <= round_next;
            rcon    <= rcon_next;
        end
    end

    // Next-state and strobe logic; registers hold unless a pop or push fires.
    always_comb begin
        state_next = state;
        key_next   = key_reg;
        round_next = round;
        rcon_next  = rcon;
        in_key_rd  = 1'b0;
        out_key_wr = 1'b0;
        case (state)
            IDLE: begin
                in_key_rd = !in_key_empty;
                if (!in_key_empty) begin
                    key_next   = in_key;
                    round_next = 4'd0;
                    rcon_next  = RCON_INIT;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_key_wr = !out_key_full;
                if (!out_key_full) begin
                    if (round == LAST_ROUND) begin
                        state_next = IDLE;
                    end else begin
                        key_next   = expanded_key;
                        round_next = round + 4'd1;
                        rcon_next  = xtime(rcon);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            in_key_rd  = 1'b0;
            out_key_wr = 1'b0;
        end
    end

    // The output FIFO sees the key register directly; it is only meaningful
    // while out_key_wr is high but never undefined otherwise.
    assign out_key   = key_reg;
    assign out_round = round;
    assign busy      = (state == EMIT);
    assign state_dbg = state;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Bench for aes128_key_sched_ctrl: a FIPS-197 key-expansion model (S-box
// derived from the GF(2^8) inverse and affine map) feeds an expected queue
// that is checked against every write; FIFO and backpressure behaviour is
// checked every cycle from the model's view of what is in flight.
module tb_aes128_key_sched_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT (default 10 rounds) ----------------
  logic [127:0] in_key = '0;
  logic         in_key_rd;
  logic         in_key_empty = 1'b1;
  logic [127:0] out_key;
  logic         out_key_wr;
  logic         out_key_full = 1'b0;
  logic [3:0]   out_round;
  logic         busy;
  logic         state_dbg;

  aes128_key_sched_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .in_key       (in_key),
    .in_key_rd    (in_key_rd),
    .in_key_empty (in_key_empty),
    .out_key      (out_key),
    .out_key_wr   (out_key_wr),
    .out_key_full (out_key_full),
    .out_round    (out_round),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- DUT (2 rounds) ----------------
  logic [127:0] in_key2 = '0;
  logic         in_key_rd2;
  logic         in_key_empty2 = 1'b1;
  logic [127:0] out_key2;
  logic         out_key_wr2;
  logic         out_key_full2 = 1'b0;
  logic [3:0]   out_round2;
  logic         busy2;
  logic         state_dbg2;

  aes128_key_sched_ctrl #(.NUM_ROUNDS(2)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .in_key       (in_key2),
    .in_key_rd    (in_key_rd2),
    .in_key_empty (in_key_empty2),
    .out_key      (out_key2),
    .out_key_wr   (out_key_wr2),
    .out_key_full (out_key_full2),
    .out_round    (out_round2),
    .busy         (busy2),
    .state_dbg    (state_dbg2)
  );

  // ---------------- counters and check helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_key(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]   sbox_m [0:255];
  logic [127:0] sched  [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    int a = a_in;
    int b = b_in;
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b % 2 == 1) p = p ^ a;
      a = a * 2;
      if (a >= 256) a = a ^ 'h11b;
      b = b / 2;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion over 44 words; word i byte j is bits [8j+:8].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[7:0]], sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]]};
        t[7:0] = t[7:0] ^ 8'(rc);
        rc = rc * 2;
        if (rc >= 256) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  // Convert a key written as a byte string (first byte leftmost) to port packing.
  function automatic logic [127:0] pk(input logic [127:0] lit);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = lit[8*(15-j) +: 8];
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [131:0] exp_q [$];
  logic [127:0] in_fifo [$];
  logic [127:0] got [0:10];
  int           wr_cyc [$];
  int           wr_rnd [$];
  int           cyc = 0;
  bit           pend = 0;
  bit           full_mode = 0;
  bit           prev_stall = 0;
  logic [127:0] prev_key;
  logic [3:0]   prev_round;
  logic [127:0] pop_k;
  logic [131:0] exp_e;
  bit           exp_busy;

  always @(negedge clock) begin
    if (pend && in_fifo.size() != 0) begin
      pop_k = in_fifo.pop_front();
      expand(pop_k);
      for (int r = 0; r <= 10; r++) exp_q.push_back({4'(r), sched[r]});
    end
    pend = 0;
    in_key_empty = (in_fifo.size() == 0);
    in_key = in_key_empty ? {$urandom(), $urandom(), $urandom(), $urandom()} : in_fifo[0];
    out_key_full = full_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    cyc++;
    if (reset) begin
      check_bit("rst_wr", out_key_wr, 1'b0);
      check_bit("rst_rd", in_key_rd, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_state", state_dbg, 1'b0);
      check_key("rst_key", out_key, '0);
      check_int("rst_round", int'(out_round), 0);
      prev_stall = 0;
    end else begin
      exp_busy = (exp_q.size() != 0);
      check_bit("busy", busy, exp_busy);
      check_bit("in_key_rd", in_key_rd, !exp_busy && !in_key_empty);
      check_bit("out_key_wr", out_key_wr, exp_busy && !out_key_full);
      if (prev_stall && busy) begin
        check_key("stall_key", out_key, prev_key);
        check_int("stall_round", int'(out_round), int'(prev_round));
      end
      if (out_key_wr && exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check_key("wr_key", out_key, exp_e[127:0]);
        check_int("wr_round", int'(out_round), int'(exp_e[131:128]));
        if (out_round <= 4'd10) got[out_round] = out_key;
        wr_cyc.push_back(cyc);
        wr_rnd.push_back(int'(out_round));
      end
      pend = in_key_rd;
      prev_stall = busy && !out_key_wr;
      prev_key = out_key;
      prev_round = out_round;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_key(input logic [127:0] k);
    in_fifo.push_back(k);
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_rnd.delete();
    for (int r = 0; r <= 10; r++) got[r] = '0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || in_fifo.size() != 0 || pend) && n < budget) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d cycles expected below %0d", tag, n, budget);
    end
    repeat (2) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] key1, key0;
  logic [127:0] k1_r1, k1_r10, k0_r1, k0_r10;
  logic [127:0] k1_sched [0:10];

  initial begin
    key1   = pk(128'h2b7e151628aed2a6abf7158809cf4f3c);
    key0   = '0;
    k1_r1  = pk(128'ha0fafe1788542cb123a339392a6c7605);
    k1_r10 = pk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    k0_r1  = pk(128'h62636363626363636263636362636363);
    k0_r10 = pk(128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    build_sbox();
    check_int("sbox_00", int'(sbox_m[0]), 'h63);
    check_int("sbox_01", int'(sbox_m[1]), 'h7c);
    check_int("sbox_53", int'(sbox_m['h53]), 'hed);
    expand(key1);
    check_key("model_k1_r1", sched[1], k1_r1);
    check_key("model_k1_r10", sched[10], k1_r10);
    for (int r = 0; r <= 10; r++) k1_sched[r] = sched[r];
    expand(key0);
    check_key("model_k0_r1", sched[1], k0_r1);
    check_key("model_k0_r10", sched[10], k0_r10);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: FIPS key, no backpressure
    clear_log();
    push_key(key1);
    wait_idle(60, "s1");
    check_int("s1_writes", wr_rnd.size(), 11);
    check_key("s1_round0", got[0], key1);
    check_key("s1_round1", got[1], k1_r1);
    check_key("s1_round10", got[10], k1_r10);
    if (wr_cyc.size() == 11) check_int("s1_span", wr_cyc[10] - wr_cyc[0], 10);

    // 2: all-zero key
    clear_log();
    push_key(key0);
    wait_idle(60, "s2");
    check_int("s2_writes", wr_rnd.size(), 11);
    check_key("s2_round1", got[1], k0_r1);
    check_key("s2_round10", got[10], k0_r10);

    // 3: random backpressure
    clear_log();
    full_mode = 1;
    push_key(key1);
    wait_idle(400, "s3");
    full_mode = 0;
    check_int("s3_writes", wr_rnd.size(), 11);
    check_key("s3_round10", got[10], k1_r10);

    // 4: two keys back-to-back
    clear_log();
    push_key(key1);
    push_key(key0);
    wait_idle(100, "s4");
    check_int("s4_writes", wr_rnd.size(), 22);
    if (wr_cyc.size() == 22) begin
      check_int("s4_gap", wr_cyc[11] - wr_cyc[10], 2);
      check_int("s4_a_last", wr_rnd[10], 10);
      check_int("s4_b_first", wr_rnd[11], 0);
    end

    // 5: reset after the 4th write
    clear_log();
    push_key(key1);
    for (int n = 0; n < 60 && wr_rnd.size() < 4; n++) @(negedge clock);
    check_int("s5_pre_writes", wr_rnd.size(), 4);
    reset = 1'b1;
    exp_q.delete();
    pend = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_int("s5_no_more", wr_rnd.size(), 4);
    clear_log();
    push_key(key0);
    wait_idle(60, "s5");
    check_int("s5_writes", wr_rnd.size(), 11);
    check_key("s5_round0", got[0], '0);
    check_key("s5_round1", got[1], k0_r1);
    check_key("s5_round10", got[10], k0_r10);

    // random keys with random backpressure
    full_mode = 1;
    for (int i = 0; i < 4; i++) begin
      push_key({$urandom(), $urandom(), $urandom(), $urandom()});
      repeat ($urandom_range(0, 15)) @(negedge clock);
    end
    wait_idle(1000, "rand");
    full_mode = 0;

    // 6: two-round instance
    @(negedge clock);
    in_key2 = key1;
    in_key_empty2 = 1'b0;
    #1;
    check_bit("s6_rd", in_key_rd2, 1'b1);
    @(negedge clock);
    in_key_empty2 = 1'b1;
    in_key2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    begin
      int nw;
      nw = 0;
      for (int n = 0; n < 6; n++) begin
        #1;
        if (out_key_wr2) begin
          if (nw <= 2) begin
            check_key("s6_key", out_key2, k1_sched[nw]);
            check_int("s6_round", int'(out_round2), nw);
          end
          nw++;
        end
        @(negedge clock);
      end
      check_int("s6_writes", nw, 3);
    end
    check_bit("s6_idle", busy2, 1'b0);
    in_key_empty2 = 1'b0;
    #1;
    check_bit("s6_rd_again", in_key_rd2, 1'b1);
    @(negedge clock);
    in_key_empty2 = 1'b1;
    repeat (6) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
